// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared types and defaults for the reusable pipeline stage register.
//
//   pipe_state_e   : occupancy of a stage (EMPTY / ONE / TWO entries held)
//   PIPE_DATA_W    : default data payload width
//   PIPE_CTRL_W    : default control payload width
//   PIPE_CNT_W     : default performance counter width
//   PIPE_SAT_FILL  : bit value replicated across a counter to form its
//                    saturation value (counters stop at all-ones)
// -----------------------------------------------------------------------------
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_e;

   localparam int PIPE_DATA_W = 32;
   localparam int PIPE_CTRL_W = 8;
   localparam int PIPE_CNT_W  = 16;

   localparam bit PIPE_SAT_FILL = 1'b1;

endpackage : pipe_pkg

// File: rtl/pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_sat_counter
//   Saturating up-counter. Increments by one on each cycle with inc=1 until it
//   reaches all-ones, where it stays until cleared. clr has priority over inc.
//
//   Ports:
//     clk  in   1      rising-edge clock
//     clr  in   1      synchronous clear (highest priority)
//     inc  in   1      increment request
//     cnt  out  CNT_W  current count (registered)
// -----------------------------------------------------------------------------
module pipe_sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = PIPE_CNT_W
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] SAT = {CNT_W{PIPE_SAT_FILL}};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != SAT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule : pipe_sat_counter

// File: rtl/pipe_stage_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid_reg
//   Reusable pipeline stage register with a valid/ready handshake and a
//   2-entry skid buffer (main + skid). in_ready is a pure function of the
//   stored state and rst, so no combinational path runs from out_ready back
//   upstream. The payload is split into a data field (holds its last value on
//   bubbles, to reduce toggling) and a control field (forced to zero whenever
//   the output slot is invalid, so write enables never leak from a bubble).
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1 on that side. Upstream must hold in_valid and its payload until
//   accepted; in_valid while in_ready=0 is ignored. Downstream sees out_data /
//   out_ctrl held stable while out_valid=1 and out_ready=0.
//
//   Priority: rst > flush > normal handshake. flush empties the stage; an
//   entry offered in the same cycle is discarded, an entry taken in the same
//   cycle counts as consumed.
//
//   Optional: define PIPE_STAGE_PERF_EN to add the CNT_W parameter and the
//   saturating stall_cnt / flush_cnt outputs.
//
//   Ports:
//     clk        in   1       rising-edge clock
//     rst        in   1       synchronous, active-high reset
//     flush      in   1       synchronous kill of all held entries
//     in_valid   in   1       upstream entry valid
//     in_ready   out  1       stage can accept (state and rst only)
//     in_data    in   DATA_W  upstream data payload
//     in_ctrl    in   CTRL_W  upstream control payload
//     out_valid  out  1       output entry valid
//     out_ready  in   1       downstream accepts
//     out_data   out  DATA_W  output data payload
//     out_ctrl   out  CTRL_W  output control payload, 0 when out_valid=0
//     dbg_state  out  2       current occupancy state
//     stall_cnt  out  CNT_W   out_valid & ~out_ready cycles (perf build)
//     flush_cnt  out  CNT_W   flushes that discarded an entry (perf build)
// -----------------------------------------------------------------------------
module pipe_stage_skid_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int CTRL_W = PIPE_CTRL_W
`ifdef PIPE_STAGE_PERF_EN
   ,
   parameter int CNT_W  = PIPE_CNT_W
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output pipe_state_e       dbg_state
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   pipe_state_e       state_q;
   logic [DATA_W-1:0] main_data_q;
   logic [CTRL_W-1:0] main_ctrl_q;
   logic [DATA_W-1:0] skid_data_q;
   logic [CTRL_W-1:0] skid_ctrl_q;

   logic in_fire;
   logic out_fire;

   assign out_valid = (state_q != EMPTY);
   assign in_ready  = (state_q != TWO) & ~rst;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // Every transition into EMPTY clears main_ctrl_q, so the registered control
   // field is already zero whenever the slot is a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else if (flush) begin
         // main_data_q is left alone: out_data keeps its last value.
         state_q     <= EMPTY;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_data_q <= in_data;
                  main_ctrl_q <= in_ctrl;
                  state_q     <= ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_data_q <= in_data;
                  main_ctrl_q <= in_ctrl;
               end else if (in_fire) begin
                  // Downstream stalled: park the new entry in the skid.
                  skid_data_q <= in_data;
                  skid_ctrl_q <= in_ctrl;
                  state_q     <= TWO;
               end else if (out_fire) begin
                  main_ctrl_q <= '0;
                  state_q     <= EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  main_data_q <= skid_data_q;
                  main_ctrl_q <= skid_ctrl_q;
                  skid_data_q <= '0;
                  skid_ctrl_q <= '0;
                  state_q     <= ONE;
               end
            end
            default: begin
               state_q     <= EMPTY;
               main_ctrl_q <= '0;
            end
         endcase
      end
   end

   assign out_data  = main_data_q;
   assign out_ctrl  = main_ctrl_q;
   assign dbg_state = state_q;

`ifdef PIPE_STAGE_PERF_EN
   logic stall_inc;
   logic flush_inc;

   assign stall_inc = out_valid & ~out_ready;
   assign flush_inc = flush & out_valid;

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .clr (rst),
      .inc (stall_inc),
      .cnt (stall_cnt)
   );

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk (clk),
      .clr (rst),
      .inc (flush_inc),
      .cnt (flush_cnt)
   );
`endif

endmodule : pipe_stage_skid_reg

// File: tb/tb_pipe_stage_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid_reg
//   Self-checking bench for pipe_stage_skid_reg. The reference is a queue of
//   entries currently held by the stage (capacity 2); outputs are derived from
//   the queue head. Directed sequences carry literal expectations; a random
//   valid/ready/flush/reset phase is checked every cycle against the queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_stage_skid_reg;
   import pipe_pkg::*;

   localparam int DW = 32;
   localparam int CW = 8;
`ifdef PIPE_STAGE_PERF_EN
   localparam int TB_CNT_W = 4;
   localparam logic [TB_CNT_W-1:0] CNT_MAX = '1;
`endif

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } ent_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   logic flush;
   logic in_valid;
   logic in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic out_valid;
   logic out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   pipe_state_e dbg_state;
`ifdef PIPE_STAGE_PERF_EN
   logic [TB_CNT_W-1:0] stall_cnt;
   logic [TB_CNT_W-1:0] flush_cnt;
`endif

   always #5 clk = ~clk;

   pipe_stage_skid_reg #(
      .DATA_W (DW),
      .CTRL_W (CW)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .CNT_W  (TB_CNT_W)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .dbg_state (dbg_state)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   // ---------------- scoreboard / counts ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Entries currently held by the stage, oldest first.
   ent_t exp_q[$];
   logic [DW-1:0] last_data;
   bit model_ok = 0;
`ifdef PIPE_STAGE_PERF_EN
   logic [TB_CNT_W-1:0] stall_ref;
   logic [TB_CNT_W-1:0] flush_ref;
`endif

   always @(posedge clk) begin
      bit had;
      bit accept;
      if (rst) begin
         exp_q.delete();
         last_data = '0;
         model_ok  = 1;
`ifdef PIPE_STAGE_PERF_EN
         stall_ref = '0;
         flush_ref = '0;
`endif
      end else if (model_ok) begin
         had    = (exp_q.size() > 0);
         accept = in_valid && (exp_q.size() < 2);
`ifdef PIPE_STAGE_PERF_EN
         if (had && !out_ready && stall_ref != CNT_MAX) stall_ref = stall_ref + 1'b1;
         if (flush && had && flush_ref != CNT_MAX) flush_ref = flush_ref + 1'b1;
`endif
         if (had) last_data = exp_q[0].d;
         if (flush) begin
            exp_q.delete();
         end else begin
            if (had && out_ready) void'(exp_q.pop_front());
            if (accept) exp_q.push_back('{d: in_data, c: in_ctrl});
         end
      end
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (model_ok) begin
         chk("in_ready",  in_ready,  (exp_q.size() < 2) && !rst);
         chk("out_valid", out_valid, exp_q.size() > 0);
         chk("out_data",  out_data,  (exp_q.size() > 0) ? exp_q[0].d : last_data);
         chk("out_ctrl",  out_ctrl,  (exp_q.size() > 0) ? exp_q[0].c : '0);
         chk("dbg_state", dbg_state, exp_q.size());
`ifdef PIPE_STAGE_PERF_EN
         chk("stall_cnt", stall_cnt, stall_ref);
         chk("flush_cnt", flush_cnt, flush_ref);
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] c);
      in_valid = 1'b1;
      in_data  = d;
      in_ctrl  = c;
      cycle();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [DW-1:0] seq;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_ctrl = '0;
      repeat (2) cycle();
      chk("rst_in_ready",  in_ready,  0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_out_ctrl",  out_ctrl,  0);
      rst = 1'b0;
      cycle();
      chk("post_rst_in_ready", in_ready, 1);

      // Streaming 1..8 with downstream always ready.
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         push(DW'(i), CW'(i + 16));
         chk("stream_valid", out_valid, 1);
         chk("stream_data",  out_data,  i);
         chk("stream_ctrl",  out_ctrl,  i + 16);
         chk("stream_ready", in_ready,  1);
      end
      in_valid = 1'b0;
      cycle();
      chk("stream_end_valid", out_valid, 0);
      chk("stream_end_data",  out_data,  8);
      chk("stream_end_ctrl",  out_ctrl,  0);

      // Backpressure: two entries fill main and skid.
      out_ready = 1'b0;
      push(32'hAA, 8'h01);
      push(32'hBB, 8'h02);
      in_valid = 1'b0;
      chk("bp_in_ready", in_ready,  0);
      chk("bp_state",    dbg_state, TWO);
      chk("bp_data",     out_data,  32'hAA);
      cycle();
      chk("bp_hold_data", out_data, 32'hAA);
      chk("bp_hold_ctrl", out_ctrl, 8'h01);
      out_ready = 1'b1;
      cycle();
      chk("bp_second_data", out_data, 32'hBB);
      chk("bp_second_ctrl", out_ctrl, 8'h02);
      chk("bp_ready_back",  in_ready, 1);
      cycle();
      chk("bp_drained", out_valid, 0);

      // Bubble safety: control zeroed, data retained.
      out_ready = 1'b0;
      push(32'hAA, 8'hFF);
      in_valid = 1'b0;
      chk("bub_ctrl_live", out_ctrl, 8'hFF);
      out_ready = 1'b1;
      cycle();
      chk("bub_valid", out_valid, 0);
      chk("bub_ctrl",  out_ctrl,  0);
      chk("bub_data",  out_data,  32'hAA);

      // Flush with a full buffer and an incoming entry.
      out_ready = 1'b0;
      push(32'h11, 8'h03);
      push(32'h22, 8'h04);
      chk("fl_state_two", dbg_state, TWO);
      flush = 1'b1; in_valid = 1'b1; in_data = 32'h33; in_ctrl = 8'h07;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid",    out_valid, 0);
      chk("fl_ctrl",     out_ctrl,  0);
      chk("fl_data",     out_data,  32'h11);
      chk("fl_in_ready", in_ready,  1);
`ifdef PIPE_STAGE_PERF_EN
      chk("fl_cnt1", flush_cnt, 1);
`endif
      // Flush in ONE while an entry is accepted: the new entry must vanish.
      push(32'h44, 8'h05);
      flush = 1'b1; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 8'h06;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl1_valid", out_valid, 0);
      chk("fl1_data",  out_data,  32'h44);
      cycle();
      chk("fl1_absent", out_valid, 0);
`ifdef PIPE_STAGE_PERF_EN
      chk("fl_cnt2", flush_cnt, 2);
`endif

      // Reset in state TWO with downstream stalled.
      push(32'h66, 8'h08);
      push(32'h77, 8'h09);
      in_valid = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      chk("mrst_valid",    out_valid, 0);
      chk("mrst_data",     out_data,  0);
      chk("mrst_ctrl",     out_ctrl,  0);
      chk("mrst_in_ready", in_ready,  0);
`ifdef PIPE_STAGE_PERF_EN
      chk("mrst_stall", stall_cnt, 0);
      chk("mrst_flush", flush_cnt, 0);
`endif
      rst = 1'b0;
      cycle();
      chk("mrst_ready_back", in_ready, 1);

      // Random valid/ready/flush/reset, checked every cycle by the model.
      seq = 32'h1000;
      for (int n = 0; n < 10000; n++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 65);
         flush     = ($urandom_range(0, 99) < 3);
         rst       = ($urandom_range(0, 999) < 2);
         in_data   = seq;
         in_ctrl   = CW'($urandom_range(0, 255));
         seq       = seq + 1;
         cycle();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_pipe_stage_skid_reg

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and bubble-safe control fields. It generalises the fixed-field stage registers (IF/ID through MEM/WB) into one reusable block. Every stage boundary can then stall or flush without combinational ready paths running through the pipeline. The payload is split into a data field, which holds on bubbles, and a control field, which is forced to zero on bubbles. Forcing the control field to zero means reg_write and mem_write can never leak from an invalid slot.

Parameters:
DATA_W, 32, width of data payload (result, read data, immediate, ...)
CTRL_W, 8, width of control payload (reg_write, mem_to_reg, rd, U_type, ...); zeroed when slot invalid
CNT_W, 16, width of performance counters (used only with PIPE_STAGE_PERF_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept; depends only on state and rst, no combinational path from out_ready
in_data  in  DATA_W  upstream data payload
in_ctrl  in  CTRL_W  upstream control payload
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  output data payload
out_ctrl  out  CTRL_W  output control payload; 0 whenever out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (PIPE_STAGE_PERF_EN only)
flush_cnt  out  CNT_W  number of flush cycles that discarded at least one valid entry (PIPE_STAGE_PERF_EN only)

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives outputs) plus a skid register.
- States: EMPTY (no entries), ONE (main valid), TWO (main and skid valid).
- Output decode: out_valid = (state != EMPTY); in_ready = (state != TWO) & ~rst.
- EMPTY: in_fire -> load main, go to ONE.
- ONE, in_fire & out_fire -> load main with the new entry, stay in ONE.
- ONE, in_fire & ~out_fire -> load skid, go to TWO.
- ONE, ~in_fire & out_fire -> go to EMPTY.
- TWO: in_ready=0. out_fire -> move skid to main, go to ONE; otherwise hold.
- Latency and throughput: 1 cycle in_fire-to-out_valid minimum; sustained throughput 1 entry/cycle; no entry is lost or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data and out_ctrl are held stable.
- Flush: next state is EMPTY and the skid is cleared.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle is treated as consumed downstream.
  - Flush beats in_fire and out_fire.
- Bubbles: out_ctrl = 0 in EMPTY. out_data retains its last value in EMPTY, to reduce toggling.
- Reset: rst beats flush.
  - On reset: state EMPTY, out_valid 0, out_data 0, out_ctrl 0, skid cleared, counters 0.
  - in_ready is 0 during the rst cycle and 1 from the first cycle after release.
  - Reset mid-transfer drops all entries.
- Overflow protection: in_valid while in_ready=0 is ignored; upstream must hold its payload.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments on each out_valid & ~out_ready cycle and saturates at all-ones.
  - flush_cnt increments on flush while state != EMPTY and saturates.
  - Both counters clear on rst.
- Undefined: stall_cnt and flush_cnt ports and their logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - the state enum pipe_state_e {EMPTY, ONE, TWO};
  - default width constants PIPE_DATA_W=32, PIPE_CTRL_W=8, PIPE_CNT_W=16;
  - a localparam for the saturation value.
- One natural sub-module, pipe_sat_counter, instantiated twice: parametrised CNT_W, inputs inc and clr, saturating.

Test Plan:
- Streaming: rst 2 cycles, then stream 0x1..0x8 with out_ready=1 -> out_valid from cycle 1 after the first in_fire, data 0x1..0x8 in order, in_ready stays 1.
- Backpressure: send A=0xAA, B=0xBB with out_ready=0 -> state TWO, in_ready=0, out_data=0xAA held. Raise out_ready -> A then B on consecutive cycles, in_ready returns 1.
- Bubble safety: in_ctrl=0xFF with a single entry, then drain -> out_ctrl=0 while EMPTY, out_data remains 0xAA.
- Flush with full buffer: state TWO, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0; the new entry is absent; flush_cnt=1 if PIPE_STAGE_PERF_EN.
- Reset mid-operation: rst while in state TWO with out_ready=0 -> next cycle all outputs 0, in_ready=0, then 1 the following cycle; 3 prior stall cycles cleared from stall_cnt.
- Randomised valid/ready for 10k cycles against a scoreboard queue -> no loss or duplication. Under PIPE_STAGE_PERF_EN, stall_cnt equals the reference count (CNT_W=4 checks saturation at 15).
